// File: rtl/subtree_rr_dispatch.sv
// subtree_rr_dispatch
//   Feeder stage for a subtree of N_OUT children. It takes one valid/ready word
//   stream and hands each word to exactly one child. Children are served in
//   strict round-robin order (0,1,..,N_OUT-1,0,..) through a one-entry
//   registered stage, so the mapping from word to child is deterministic.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   S_EMPTY | no word held; in_ready=1, out_valid=0
//   S_FULL  | word held in out_data for child ptr; out_valid=1<<ptr
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   producer word valid
//   in_ready   stage can take a word this cycle
//   in_data    producer word [DW]
//   out_valid  one-hot valid toward child ptr [N_OUT]
//   out_ready  per-child ready [N_OUT]; only bit ptr is looked at
//   out_data   held word, shared by all children [DW]
//   busy       stage holds a word
//   stat_sel   child index for counter readout   (SUBTREE_DISPATCH_STATS_EN)
//   stat_cnt   saturating accepted-word count     (SUBTREE_DISPATCH_STATS_EN)
//
// Build option
//   SUBTREE_DISPATCH_STATS_EN : adds per-child saturating delivery counters and
//   the stat_sel/stat_cnt readout. Dispatch behaviour is the same either way.

module subtree_rr_dispatch #(
    parameter int DW    = 8,
    parameter int N_OUT = 5,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_data,
    output logic [N_OUT-1:0]          out_valid,
    input  logic [N_OUT-1:0]          out_ready,
    output logic [DW-1:0]             out_data,
    output logic                      busy
`ifdef SUBTREE_DISPATCH_STATS_EN
    ,
    input  logic [$clog2(N_OUT)-1:0]  stat_sel,
    output logic [CNT_W-1:0]          stat_cnt
`endif
);

    localparam int PW = $clog2(N_OUT);

    // Elaboration-time guard on the legal parameter range.
    generate
        if (N_OUT < 2 || N_OUT > 16) begin : g_bad_n_out
            $error("subtree_rr_dispatch: N_OUT must be in 2..16");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("subtree_rr_dispatch: CNT_W must be at least 1");
        end
    endgenerate

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [DW-1:0]  data_q, data_d;
    logic           full;
    logic           in_fire;
    logic           out_fire;

    assign full     = (state_q == S_FULL);
    // Only the targeted child's ready matters; strict order, no skipping.
    assign out_fire = full & out_ready[ptr_q];
    // The single combinational path out_ready -> in_ready: lets a full stage
    // refill in the same cycle it drains, sustaining one word per clock.
    assign in_ready = ~full | out_fire;
    assign in_fire  = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        case (state_q)
            S_EMPTY: begin
                if (in_fire) begin
                    data_d  = in_data;
                    state_d = S_FULL;
                end
            end
            S_FULL: begin
                if (out_fire) begin
                    // Explicit wrap so non-power-of-two N_OUT never skips.
                    ptr_d = (ptr_q == PW'(N_OUT - 1)) ? '0 : ptr_q + PW'(1);
                    if (in_fire) begin
                        data_d = in_data;
                    end else begin
                        // out_data keeps its last value while empty.
                        state_d = S_EMPTY;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign out_valid = full ? (N_OUT'(1) << ptr_q) : '0;
    assign out_data  = data_q;
    assign busy      = full;

`ifdef SUBTREE_DISPATCH_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_OUT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_OUT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_OUT; i++) begin
                // Saturate at all-ones instead of wrapping.
                if (out_fire && (ptr_q == PW'(i)) && (cnt_q[i] != '1)) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Decoded read so out-of-range selects (>= N_OUT) return zero.
    always_comb begin
        stat_cnt = '0;
        for (int i = 0; i < N_OUT; i++) begin
            if (stat_sel == PW'(i)) begin
                stat_cnt = cnt_q[i];
            end
        end
    end
`endif

endmodule
